// File: rtl/gate_pkg.sv
// rtl/gate_pkg.sv - opcode types and gate helper functions for the reduction pipeline
package gate_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_RSV6 = 3'd6,
        OP_RSV7 = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        BASE_AND = 2'd0,
        BASE_OR  = 2'd1,
        BASE_XOR = 2'd2
    } base_e;

    // Fill bit for masked-off and padding positions: the identity element of the base gate.
    function automatic logic op_identity(input op_e op);
        case (op)
            OP_AND, OP_NAND: return 1'b1;
            default:         return 1'b0;
        endcase
    endfunction

    // Base gate used inside the tree; reserved opcodes reduce harmlessly as OR.
    function automatic base_e op_base(input op_e op);
        case (op)
            OP_AND, OP_NAND: return BASE_AND;
            OP_XOR, OP_XNOR: return BASE_XOR;
            default:         return BASE_OR;
        endcase
    endfunction

    // Inverting opcodes are reduced with their base gate and flipped once at the end.
    function automatic logic op_inverts(input op_e op);
        case (op)
            OP_NAND, OP_NOR, OP_XNOR: return 1'b1;
            default:                  return 1'b0;
        endcase
    endfunction

    function automatic logic op_reserved(input op_e op);
        return (op == OP_RSV6) || (op == OP_RSV7);
    endfunction

    function automatic logic gate_combine(input base_e base, input logic a, input logic b);
        case (base)
            BASE_AND: return a & b;
            BASE_XOR: return a ^ b;
            default:  return a | b;
        endcase
    endfunction

    // Tree levels already reduced once 'stages' tree stages have been passed.
    function automatic int levels_done(input int stages, input int lvl_per_stg, input int levels);
        int d;
        d = stages * lvl_per_stg;
        if (d < 0) begin
            d = 0;
        end
        if (d > levels) begin
            d = levels;
        end
        return d;
    endfunction

endpackage

// File: rtl/reduce_stage.sv
// rtl/reduce_stage.sv - combinational pairwise reduction over a fixed number of tree levels
module reduce_stage
    import gate_pkg::*;
#(
    parameter int IN_W   = 2,
    parameter int LEVELS = 1
) (
    input  base_e                      base_i,
    input  logic [IN_W-1:0]            data_i,
    output logic [(IN_W>>LEVELS)-1:0]  data_o
);

    // Level l holds IN_W >> l partial results; level 0 is the raw input.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int LW = IN_W >> l;
        logic [LW-1:0] v;

        if (l == 0) begin : g_in
            assign v = data_i;
        end else begin : g_red
            // Combine adjacent pairs of the previous level with the base gate.
            always_comb begin
                v = '0;
                for (int j = 0; j < LW; j++) begin
                    v[j] = gate_combine(base_i, g_lvl[l-1].v[2*j], g_lvl[l-1].v[2*j+1]);
                end
            end
        end
    end

    assign data_o = g_lvl[LEVELS].v;

endmodule

// File: rtl/reduce_gate_pipe.sv
// rtl/reduce_gate_pipe.sv - pipelined masked AND/OR/XOR reduction with flow control and true-result counter
module reduce_gate_pipe
    import gate_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int LVL_PER_STG = 1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] in_mask,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic [2:0]       out_op,
    output logic             out_err,
    input  logic             clear_count,
    output logic [CNT_W-1:0] ones_count
);

    localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 0;
    localparam int PW     = 1 << LEVELS;
    localparam int NTREE  = (LEVELS + LVL_PER_STG - 1) / LVL_PER_STG;
    localparam int NSTG   = 1 + NTREE;
    localparam int LAST   = NSTG - 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NSTG-1:0]  vld_q;
    logic [NSTG-1:0]  vld_d;
    logic [NSTG-1:0]  rdy;
    logic [NSTG-1:0]  down_rdy;
    logic [NSTG-1:0]  load;
    logic             in_fill;
    logic [PW-1:0]    padded;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Replace masked-off bits and the power-of-two padding with the opcode's identity.
    always_comb begin
        in_fill           = op_identity(op_e'(in_op));
        padded            = {PW{in_fill}};
        padded[WIDTH-1:0] = (in_data & in_mask) | ({WIDTH{in_fill}} & ~in_mask);
    end

    // Ready ripples back from the consumer; a stage accepts when empty or when it is draining.
    always_comb begin
        logic acc;
        logic up;
        rdy      = '0;
        down_rdy = '0;
        load     = '0;
        vld_d    = vld_q;
        acc      = out_ready;
        for (int s = LAST; s >= 0; s--) begin
            down_rdy[s] = acc;
            acc         = !vld_q[s] || acc;
            rdy[s]      = acc;
        end
        up = in_valid;
        for (int s = 0; s < NSTG; s++) begin
            load[s]  = up && rdy[s];
            vld_d[s] = load[s] || (vld_q[s] && !down_rdy[s]);
            up       = vld_q[s];
        end
    end

    // Per-stage occupancy flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    for (genvar s = 0; s < NSTG; s++) begin : g_stg
        localparam int DONE_IN  = (s == 0) ? 0 : levels_done(s - 1, LVL_PER_STG, LEVELS);
        localparam int DONE_OUT = levels_done(s, LVL_PER_STG, LEVELS);
        localparam int IN_W     = PW >> DONE_IN;
        localparam int OUT_W    = PW >> DONE_OUT;

        logic [IN_W-1:0]  src;
        op_e              src_op;
        base_e            src_base;
        logic [OUT_W-1:0] red;
        logic [OUT_W-1:0] data_d;
        logic [OUT_W-1:0] data_q;
        op_e              op_q;

        if (s == 0) begin : g_head
            assign src    = padded;
            assign src_op = op_e'(in_op);
        end else begin : g_link
            assign src    = g_stg[s-1].data_q;
            assign src_op = g_stg[s-1].op_q;
        end

        assign src_base = op_base(src_op);

        reduce_stage #(
            .IN_W   (IN_W),
            .LEVELS (DONE_OUT - DONE_IN)
        ) u_reduce (
            .base_i (src_base),
            .data_i (src),
            .data_o (red)
        );

        // The final stage applies inversion and forces reserved opcodes to a zero result.
        always_comb begin
            data_d = red;
            if (s == LAST) begin
                if (op_reserved(src_op)) begin
                    data_d = '0;
                end else begin
                    data_d = red ^ {OUT_W{op_inverts(src_op)}};
                end
            end
        end

        // Stage payload: partial reduction plus the opcode that travels with it.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q <= '0;
                op_q   <= OP_AND;
            end else if (load[s]) begin
                data_q <= data_d;
                op_q   <= src_op;
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld_q[LAST];
    assign out_bit   = g_stg[LAST].data_q[0];
    assign out_op    = g_stg[LAST].op_q;
    assign out_err   = op_reserved(g_stg[LAST].op_q);

    // Count accepted true results; clear has priority and the count sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_count) begin
            cnt_d = '0;
        end else if (out_valid && out_ready && out_bit && !out_err && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Result counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ones_count = cnt_q;

endmodule

// File: doc/reduce_gate_pipe.md
Name: reduce_gate_pipe

Overview:
- Parametrised, pipelined successor to the fixed 4-/3-input AND/OR gate test netlists.
- Reduces a WIDTH-bit operand vector to a single bit under a per-transaction gate opcode (AND/OR/XOR and their inverses), with a per-bit mask.
- Has valid/ready flow control and a saturating counter of true results.
- Sits between a stimulus source and a result checker in the gate-evaluation datapath.

Parameters:
- WIDTH, 8, operand width, >=1.
- LVL_PER_STG, 1, tree levels evaluated between pipeline registers, >=1.
- CNT_W, 8, width of ones_count.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand offered.
- in_ready  output  1  operand accepted this cycle when in_valid&&in_ready.
- in_data  input  WIDTH  operand bits.
- in_mask  input  WIDTH  1 = bit participates; 0 = bit replaced by the op identity.
- in_op  input  3  0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6/7 reserved.
- out_valid  output  1  result held.
- out_ready  input  1  consumer accepts.
- out_bit  output  1  reduction result.
- out_op  output  3  opcode of the result.
- out_err  output  1  result came from a reserved opcode.
- clear_count  input  1  synchronous clear of ones_count.
- ones_count  output  CNT_W  count of accepted true results.

Behaviour:
- Reset (async on rst_n low): all stage valids 0, out_valid=0, out_bit=0, out_op=0, out_err=0, ones_count=0.
- in_ready is combinational: 1 when stage 0 is empty or advancing this cycle. It is 1 immediately after reset.
- Masking at the input stage:
  - AND/NAND: masked bits forced to 1.
  - OR/NOR/XOR/XNOR: masked bits forced to 0.
  - Vector padded with the identity to 2^LEVELS, where LEVELS = clog2(WIDTH) (0 when WIDTH=1).
- Tree:
  - Each level combines adjacent pairs with the base op (AND, OR or XOR).
  - A register is placed after every LVL_PER_STG levels.
  - Inversion for NAND/NOR/XNOR is applied in the last stage.
  - Opcode travels with the data.
- Latency with out_ready held at 1: NSTG = 1 + ceil(LEVELS/LVL_PER_STG) cycles from input handshake to out_valid.
  - WIDTH=8, LVL_PER_STG=1: 4.
  - WIDTH=1: 1.
- Throughput: one result per cycle when unstalled.
- Flow control:
  - Each stage has its own valid.
  - A stage loads when it is empty or its contents move on. Bubbles collapse.
  - out_valid && !out_ready freezes the output and backs up upstream stages.
  - No data is ever lost or duplicated.
- Reserved opcodes (6/7): out_bit=0, out_err=1. Latency is unchanged and the result is not counted.
- ones_count:
  - Increments on an output handshake with out_bit=1 and out_err=0.
  - Saturates at 2^CNT_W-1.
  - clear_count wins over a simultaneous increment (result 0).
- Outputs are registered.
- Mid-operation reset discards all in-flight items. No output handshake occurs for them.

Decomposition:
- Shared package gate_pkg holds:
  - typedef op_e for the opcodes and their values;
  - function op_identity(op_e) returning the mask fill bit;
  - function op_base(op_e) returning the base gate;
  - function op_inverts(op_e).
- One sub-module: reduce_stage (parameters IN_W, LEVELS), the combinational pairwise reduction over LEVELS levels. It is instanced once per pipeline stage by a generate loop.

Test Plan (WIDTH=8, LVL_PER_STG=1, CNT_W=4):
- Reset, then one item: in_data=8'hFF, mask=8'hFF, op=AND, out_ready=1 -> out_valid rises exactly 4 cycles after the handshake; out_bit=1, ones_count=1.
- Masking: data=8'h0F, mask=8'h0F, op=AND -> 1; same operand with op=NAND -> 0; data=8'h01, mask=8'hFE, op=OR -> 0; data=8'h07, mask=8'hFF, op=XOR -> 1, op=XNOR -> 0.
- Back-to-back stream of 6 items with out_ready deasserted for 3 cycles mid-stream -> all 6 results emerge in order, none dropped or duplicated, out_bit stable while stalled; in_ready drops only once all 4 stages are full.
- Reserved op 6 with data=8'hFF -> out_bit=0, out_err=1, ones_count unchanged.
- Send 17 true results -> ones_count saturates at 15; assert clear_count in the same cycle as a true handshake -> ones_count=0.
- rst_n pulsed low with 3 items in flight -> out_valid=0 immediately, no stale result afterwards, in_ready=1; a new item then returns with latency 4.
